// File: rtl/register_file.sv
// 32 x N register file: two combinational read ports, one decoded write port.
// x0 is hardwired to zero; writes land on the rising edge with no read bypass.

module decoder_5_to_32 (
    input  logic [4:0]  in,
    input  logic        ena,
    output logic [31:0] out
);
    always_comb begin
        out = '0;
        if (ena) out[in] = 1'b1;
    end
endmodule

module register_cell #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (we) q <= d;
    end
endmodule

module register_file #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  logic [4:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [4:0]   rd_addr0,
    output logic [N-1:0] rd_data0,
    input  logic [4:0]   rd_addr1,
    output logic [N-1:0] rd_data1
);
    logic [31:0]         dec_out;
    logic [31:0][N-1:0]  regs;
    logic                unused_dec0;

    decoder_5_to_32 u_dec (
        .in  (wr_addr),
        .ena (wr_ena),
        .out (dec_out)
    );

    // x0 has no storage, so its decoder line goes nowhere.
    assign unused_dec0 = dec_out[0];
    assign regs[0]     = '0;

    genvar k;
    generate
        for (k = 1; k < 32; k++) begin : g_reg
            register_cell #(.N(N)) u_cell (
                .clk (clk),
                .rst (rst),
                .we  (dec_out[k]),
                .d   (wr_data),
                .q   (regs[k])
            );
        end
    endgenerate

    assign rd_data0 = regs[rd_addr0];
    assign rd_data1 = regs[rd_addr1];
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: array model checked every cycle plus literal checks.

module tb_register_file;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr_ena = 1'b0;
    logic [4:0]   wr_addr = '0;
    logic [N-1:0] wr_data = '0;
    logic [4:0]   rd_addr0 = '0;
    logic [N-1:0] rd_data0;
    logic [4:0]   rd_addr1 = '0;
    logic [N-1:0] rd_data1;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] model [32];
    bit           model_ok = 1'b0;

    register_file #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (rd_addr0),
        .rd_data0 (rd_data0),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1)
    );

    always #5 clk = ~clk;

    // Model: reset clears everything, enabled writes to x1..x31 take effect at the edge.
    always @(posedge clk) begin
        if (rst) begin
            model_ok = 1'b1;
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (model_ok && wr_ena && wr_addr != 5'd0) begin
            model[wr_addr] = wr_data;
        end
    end

    // Reads are combinational, so mid-cycle they must match the pre-edge model state.
    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if (rd_data0 !== model[rd_addr0]) begin
                errors++;
                $display("FAIL port0 addr=%0d got=%h exp=%h t=%0t", rd_addr0, rd_data0, model[rd_addr0], $time);
            end
            checks++;
            if (rd_data1 !== model[rd_addr1]) begin
                errors++;
                $display("FAIL port1 addr=%0d got=%h exp=%h t=%0t", rd_addr1, rd_data1, model[rd_addr1], $time);
            end
        end
    end

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then return 1 time unit after the edge.
    task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                         input logic [N-1:0] wd, input logic [4:0] a0, input logic [4:0] a1);
        rst = r; wr_ena = we; wr_addr = wa; wr_data = wd;
        rd_addr0 = a0; rd_addr1 = a1;
        @(posedge clk);
        #1;
    endtask

    // Change read addresses only, no clock; disables writes so nothing pending.
    task automatic peek(input logic [4:0] a0, input logic [4:0] a1);
        rst = 1'b0; wr_ena = 1'b0;
        rd_addr0 = a0; rd_addr1 = a1;
        #1;
    endtask

    logic [N-1:0] exp_v;

    initial begin
        #1;
        drive(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0);
        peek(5'd5, 5'd0);
        chk("reset_x5", rd_data0, 32'h0);
        chk("reset_x0", rd_data1, 32'h0);

        // Reset clears a written register
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        peek(5'd5, 5'd0);
        chk("write_x5", rd_data0, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 5'd0, '0, 5'd5, 5'd5);
        peek(5'd5, 5'd5);
        chk("reset_clear_x5", rd_data0, 32'h0);

        // Reset beats a same-edge write
        drive(1'b1, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
        peek(5'd7, 5'd7);
        chk("reset_priority_x7", rd_data1, 32'h0);

        // Basic write, both ports, others untouched
        drive(1'b0, 1'b1, 5'd3, 32'hCAFEF00D, 5'd0, 5'd0);
        peek(5'd3, 5'd3);
        chk("basic_p0", rd_data0, 32'hCAFEF00D);
        chk("basic_p1", rd_data1, 32'hCAFEF00D);
        for (int k = 0; k < 32; k++) begin
            if (k != 3) begin
                peek(5'(k), 5'(31 - k));
                chk("basic_other", rd_data0, 32'h0);
            end
        end

        // x0 ignores writes
        drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        peek(5'd0, 5'd0);
        chk("x0_immutable", rd_data0, 32'h0);

        // Disabled write
        drive(1'b0, 1'b0, 5'd9, 32'h55555555, 5'd9, 5'd9);
        peek(5'd9, 5'd9);
        chk("write_disabled_x9", rd_data0, 32'h0);

        // Read during write: old value until the edge, new one after
        drive(1'b0, 1'b1, 5'd4, 32'h11111111, 5'd0, 5'd4);
        rst = 1'b0; wr_ena = 1'b1; wr_addr = 5'd4; wr_data = 32'h22222222; rd_addr1 = 5'd4;
        #1;
        chk("rdw_before", rd_data1, 32'h11111111);
        @(posedge clk);
        #1;
        chk("rdw_after", rd_data1, 32'h22222222);

        // Sweep all registers
        for (int k = 1; k < 32; k++)
            drive(1'b0, 1'b1, 5'(k), 32'(k) * 32'h01010101, 5'(k), 5'(k - 1));
        for (int k = 0; k < 32; k++) begin
            peek(5'(k), 5'(k));
            exp_v = 32'(k) * 32'h01010101;
            chk("sweep_p0", rd_data0, exp_v);
            chk("sweep_p1", rd_data1, exp_v);
        end
        chk("sweep_x31_lit", dut.rd_data0, 32'h1F1F1F1F);

        // Mixed traffic with a mid-sequence reset, checked by the model each cycle
        for (int i = 0; i < 60; i++)
            drive(i == 30, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  N'($urandom), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
